vga_pixel_pipe: RTL and testbench
=================================

# vga_pixel_pipe

Pixel fetch pipeline between `vga_core` and the RGB pins. Takes raw beam coordinates and sync/blank, generates a downscaled image-ROM address with an incremental row/column accumulator (no multiplier), and absorbs the ROM read latency. Delays hsync/vsync/de to match, so colour, syncs and blanking leave the block aligned on the same cycle. Replaces the combinational address arithmetic and unregistered colour muxing in the top level.

## Interface

Parameters:
- `HSZ`, 10, width of hcount_i
- `VSZ`, 10, width of vcount_i
- `SCALE_LOG2`, 2, log2 of pixel replication factor (both axes)
- `IMG_W`, 160, image width in source pixels
- `IMG_H`, 120, image height in source pixels
- `AW`, 15, ROM address width
- `CW`, 12, colour width (4:4:4 RGB)
- `ROM_LAT`, 1, ROM read latency in cycles (≥1)

Ports:
- `clk_i` in 1: pixel clock; the only clock.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `hcount_i` in HSZ: beam x from vga_core
- `vcount_i` in VSZ: beam y from vga_core
- `de_i` in 1: active-video flag
- `hsync_i`, `vsync_i` in 1: syncs from vga_core
- `rom_addr_o` out AW: registered ROM address
- `rom_data_i` in CW: ROM data, valid ROM_LAT cycles after address
- `r_o`, `g_o`, `b_o` out 4: pixel colour
- `hsync_o`, `vsync_o`, `de_o` out 1: delayed syncs/enable

## Operation

- Let S = 1<<SCALE_LOG2, sx = hcount_i>>SCALE_LOG2, sy = vcount_i>>SCALE_LOG2.
- Required: for every in-image active pixel, rom_addr_o = sy*IMG_W + sx.
- Row accumulator `row_base` (AW bits), updated at each de_i rising edge (de_i & ~de_q):
  - vcount_i == 0 → 0
  - else vcount_i[SCALE_LOG2-1:0] == 0 → row_base + IMG_W
  - else hold
- Column accumulator `col` and sub-counter `hsub` (SCALE_LOG2 bits):
  - de_i low → col = 0, hsub = 0
  - de_i high → hsub++ (wraps); col++ when hsub == S-1
- rom_addr_o <= (updated row_base) + col, using the same-cycle updated values at the line-start pixel.
- In-image flag: sx < IMG_W && sy < IMG_H. Outside the image, rom_addr_o holds its last value and the pixel outputs black.
- Colour stage: if delayed de and delayed in-image flag are both set → {r,g,b} = rom_data_i[11:8], [7:4], [3:0]; else 0.

## Timing

- Latency L = ROM_LAT + 2 cycles from inputs to r/g/b/hsync_o/vsync_o/de_o: 1 cycle address register, ROM_LAT ROM, 1 cycle output register.
- rom_addr_o appears 1 cycle after the coordinates are presented.
- hsync/vsync/de/in-image go through an L-deep shift register; all outputs are registered.
- Reset values: r/g/b = 0, de_o = 0, hsync_o = vsync_o = 1 (inactive, negative polarity), rom_addr_o = 0, row_base = col = hsub = 0, shift-register de/in-image bits = 0, sync bits = 1.
- Reset mid-frame: everything clears immediately (async). Outputs stay black until the first frame start (vcount_i == 0 line); a partial frame after reset may address wrongly but must stay blanked if de is low.
- Sum wider than AW: truncate; IMG_W*IMG_H ≤ 2^AW is a parameter precondition.

## Structure

- Shared package `vga_pkg`: colour-width constant, 4:4:4 field slices, sync reset level constant.
- One natural sub-module: `vga_delay_line` (parameterised depth and width, reset value per bit), used for the sync/de/in-image alignment.
- Address accumulators and colour stage stay in the top body.

## Test plan

- Reset asserted for 5 cycles → rgb = 0, de_o = 0, hsync_o = vsync_o = 1, rom_addr_o = 0.
- Pixel (0,0) with de rising, ROM_LAT = 1 → rom_addr_o = 0 at +1; rgb = ROM[0] fields, de_o = 1 at +3.
- Pixel (7,5) → addr 161; pixel (639,479) → addr 19199; full 640x480 frame matches golden addr at every active cycle.
- Toggle hsync_i/vsync_i at arbitrary cycles → outputs reproduce them exactly L cycles later; de_i low → rgb = 0.
- IMG_W = 100 build: hcount 400 on an active line → rgb = 0, rom_addr_o unchanged from hcount 399.
- Deassert rstn_i mid-line at (320,200), release → black until vcount 0, then the next frame's addresses match golden.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA pixel path.
// Colour is 4:4:4 RGB; syncs are negative polarity.
package vga_pkg;

    localparam int unsigned COLOR_W = 12;
    localparam logic SYNC_IDLE = 1'b1;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    function automatic rgb_t unpack_rgb(input logic [COLOR_W-1:0] d);
        rgb_t c;
        c.r = d[11:8];
        c.g = d[7:4];
        c.b = d[3:0];
        return c;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a per-bit reset value.
// Keeps syncs/enable aligned with the ROM fetch.
module vga_delay_line #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= RST_VAL;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_pixel_pipe.sv
// Pixel fetch pipeline: downscaled ROM addressing without a multiplier, ROM latency
// absorption and sync/blank alignment so colour and syncs leave on the same cycle.
module vga_pixel_pipe
    import vga_pkg::*;
#(
    parameter int unsigned HSZ        = 10,
    parameter int unsigned VSZ        = 10,
    parameter int unsigned SCALE_LOG2 = 2,
    parameter int unsigned IMG_W      = 160,
    parameter int unsigned IMG_H      = 120,
    parameter int unsigned AW         = 15,
    parameter int unsigned CW         = COLOR_W,
    parameter int unsigned ROM_LAT    = 1
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    input  logic [HSZ-1:0] hcount_i,
    input  logic [VSZ-1:0] vcount_i,
    input  logic           de_i,
    input  logic           hsync_i,
    input  logic           vsync_i,
    output logic [AW-1:0]  rom_addr_o,
    input  logic [CW-1:0]  rom_data_i,
    output logic [3:0]     r_o,
    output logic [3:0]     g_o,
    output logic [3:0]     b_o,
    output logic           hsync_o,
    output logic           vsync_o,
    output logic           de_o
);

    localparam int unsigned DLY = ROM_LAT + 1;
    localparam logic [HSZ-1:0] IMG_W_X  = HSZ'(IMG_W);
    localparam logic [VSZ-1:0] IMG_H_Y  = VSZ'(IMG_H);
    localparam logic [AW-1:0]  ROW_STEP = AW'(IMG_W);

    logic [HSZ-1:0]        sx;
    logic [VSZ-1:0]        sy;
    logic                  de_q, synced_q;
    logic [AW-1:0]         row_base_q, row_base_d;
    logic [AW-1:0]         col_q, col_d;
    logic [SCALE_LOG2-1:0] hsub_q, hsub_d;
    logic [AW-1:0]         rom_addr_q, rom_addr_d;
    logic                  line_start, synced, in_img;

    assign sx = hcount_i >> SCALE_LOG2;
    assign sy = vcount_i >> SCALE_LOG2;

    always_comb begin
        line_start = de_i & ~de_q;
        // Pixels stay blanked after reset until a frame start re-seeds the row accumulator.
        synced     = synced_q | (de_i & (vcount_i == '0));
        in_img     = synced & (sx < IMG_W_X) & (sy < IMG_H_Y);

        row_base_d = row_base_q;
        if (line_start) begin
            if (vcount_i == '0) begin
                row_base_d = '0;
            end else if (vcount_i[SCALE_LOG2-1:0] == '0) begin
                row_base_d = row_base_q + ROW_STEP;
            end
        end

        col_d  = col_q;
        hsub_d = hsub_q;
        if (!de_i) begin
            col_d  = '0;
            hsub_d = '0;
        end else begin
            hsub_d = hsub_q + SCALE_LOG2'(1);
            if (&hsub_q) col_d = col_q + AW'(1);
        end

        rom_addr_d = rom_addr_q;
        if (de_i && in_img) rom_addr_d = row_base_d + col_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            de_q       <= 1'b0;
            synced_q   <= 1'b0;
            row_base_q <= '0;
            col_q      <= '0;
            hsub_q     <= '0;
            rom_addr_q <= '0;
        end else begin
            de_q       <= de_i;
            synced_q   <= synced;
            row_base_q <= row_base_d;
            col_q      <= col_d;
            hsub_q     <= hsub_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    assign rom_addr_o = rom_addr_q;

    // Bit order: {hsync, vsync, de, in_img}; the output register adds the last stage.
    logic [3:0] ctl_dly;

    vga_delay_line #(
        .DEPTH   (DLY),
        .WIDTH   (4),
        .RST_VAL ({SYNC_IDLE, SYNC_IDLE, 2'b00})
    ) u_ctl_dly (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    ({hsync_i, vsync_i, de_i, in_img}),
        .q_o    (ctl_dly)
    );

    rgb_t pix_q;
    logic hsync_q, vsync_q, de_out_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pix_q    <= '0;
            hsync_q  <= SYNC_IDLE;
            vsync_q  <= SYNC_IDLE;
            de_out_q <= 1'b0;
        end else begin
            pix_q    <= (ctl_dly[1] && ctl_dly[0]) ? unpack_rgb(rom_data_i[COLOR_W-1:0]) : '0;
            hsync_q  <= ctl_dly[3];
            vsync_q  <= ctl_dly[2];
            de_out_q <= ctl_dly[1];
        end
    end

    assign r_o     = pix_q.r;
    assign g_o     = pix_q.g;
    assign b_o     = pix_q.b;
    assign hsync_o = hsync_q;
    assign vsync_o = vsync_q;
    assign de_o    = de_out_q;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Randomised bench for vga_pixel_pipe: two builds (IMG_W 160 and 100) share the
// beam stimulus and are checked against a coordinate-level reference model.
module tb_vga_pixel_pipe;

    localparam int unsigned W_A   = 160;
    localparam int unsigned W_B   = 100;
    localparam int unsigned IMG_H = 120;

    logic        clk = 1'b0;
    logic        rstn;
    logic [9:0]  hcount, vcount;
    logic        de, hsync, vsync;
    logic [14:0] addr_a, addr_b;
    logic [11:0] rom_a, rom_b;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic        hs_a, vs_a, de_a, hs_b, vs_b, de_b;

    always #5 clk = ~clk;

    vga_pixel_pipe u_dut_a (
        .clk_i(clk), .rstn_i(rstn), .hcount_i(hcount), .vcount_i(vcount), .de_i(de),
        .hsync_i(hsync), .vsync_i(vsync), .rom_addr_o(addr_a), .rom_data_i(rom_a),
        .r_o(r_a), .g_o(g_a), .b_o(b_a), .hsync_o(hs_a), .vsync_o(vs_a), .de_o(de_a)
    );

    vga_pixel_pipe #(.IMG_W(W_B)) u_dut_b (
        .clk_i(clk), .rstn_i(rstn), .hcount_i(hcount), .vcount_i(vcount), .de_i(de),
        .hsync_i(hsync), .vsync_i(vsync), .rom_addr_o(addr_b), .rom_data_i(rom_b),
        .r_o(r_b), .g_o(g_b), .b_o(b_b), .hsync_o(hs_b), .vsync_o(vs_b), .de_o(de_b)
    );

    function automatic logic [11:0] rom_fn(input int unsigned a);
        return 12'((a * 37 + 11) ^ (a >> 4));
    endfunction

    // Image ROM with one cycle of read latency.
    always @(posedge clk) begin
        rom_a <= rom_fn(32'(addr_a));
        rom_b <= rom_fn(32'(addr_b));
    end

    typedef struct {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] pix_a;
        logic [11:0] pix_b;
    } exp_t;

    exp_t        hist[$];
    logic [14:0] exp_addr_a, exp_addr_b;
    bit          synced;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_t e;
        e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.pix_a = '0; e.pix_b = '0;
        hist.delete();
        hist.push_back(e);
        hist.push_back(e);
        exp_addr_a = '0;
        exp_addr_b = '0;
        synced     = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_rgb_a"}, {r_a, g_a, b_a}, 0);
        check_eq({tag, "_rgb_b"}, {r_b, g_b, b_b}, 0);
        check_eq({tag, "_de"}, de_a, 0);
        check_eq({tag, "_hs"}, hs_a, 1);
        check_eq({tag, "_vs"}, vs_a, 1);
        check_eq({tag, "_addr_a"}, addr_a, 0);
        check_eq({tag, "_addr_b"}, addr_b, 0);
    endtask

    task automatic cycle(input int h, input int v, input bit d);
        exp_t e;
        bit   in_a, in_b;
        int   sx, sy;
        hcount = 10'(h);
        vcount = 10'(v);
        de     = d;
        if ($urandom_range(7) == 0) hsync = ~hsync;
        if ($urandom_range(15) == 0) vsync = ~vsync;

        sx = h >> 2;
        sy = v >> 2;
        if (d && v == 0) synced = 1'b1;
        in_a = synced && sx < int'(W_A) && sy < int'(IMG_H);
        in_b = synced && sx < int'(W_B) && sy < int'(IMG_H);
        if (d && in_a) exp_addr_a = 15'(sy * int'(W_A) + sx);
        if (d && in_b) exp_addr_b = 15'(sy * int'(W_B) + sx);
        e.hs    = hsync;
        e.vs    = vsync;
        e.de    = d;
        e.pix_a = (d && in_a) ? rom_fn(sy * W_A + sx) : 12'h0;
        e.pix_b = (d && in_b) ? rom_fn(sy * W_B + sx) : 12'h0;
        hist.push_back(e);

        @(posedge clk);
        #1;
        check_eq("addr_a", addr_a, exp_addr_a);
        check_eq("addr_b", addr_b, exp_addr_b);
        if (d && synced && h == 7 && v == 5) check_eq("addr_7_5", addr_a, 161);
        if (d && synced && h == 639 && v == 479) check_eq("addr_639_479", addr_a, 19199);
        if (d && synced && h == 400 && v == 5) check_eq("addr_b_hold_400", addr_b, 199);

        e = hist.pop_front();
        check_eq("rgb_a", {r_a, g_a, b_a}, e.pix_a);
        check_eq("rgb_b", {r_b, g_b, b_b}, e.pix_b);
        check_eq("hsync", hs_a, e.hs);
        check_eq("vsync", vs_a, e.vs);
        check_eq("de", de_a, e.de);
        check_eq("de_b", {hs_b, vs_b, de_b}, {e.hs, e.vs, e.de});
    endtask

    // Asynchronous assert between edges, held for ncyc cycles, released off-edge.
    task automatic do_reset(input int ncyc);
        #2 rstn = 1'b0;
        #1 check_reset_state("async_rst");
        repeat (ncyc) @(posedge clk);
        #1 check_reset_state("held_rst");
        rstn = 1'b1;
        model_reset();
    endtask

    // Short random lines keep the run small; a few full-width lines exercise edges.
    task automatic run_frame(input bit reset_mid);
        for (int v = 0; v < 485; v++) begin
            int len;
            if (v >= 480) len = 0;
            else if (v == 0 || v == 5 || v == 200 || v == 479 || $urandom_range(63) == 0) len = 640;
            else len = int'($urandom_range(16, 1));
            for (int h = 0; h < len + 6; h++) begin
                if (reset_mid && v == 200 && h == 320) do_reset(5);
                cycle(h, v, h < len);
            end
        end
    endtask

    initial begin
        rstn   = 1'b0;
        hcount = '0;
        vcount = '0;
        de     = 1'b0;
        hsync  = 1'b1;
        vsync  = 1'b1;
        repeat (5) @(posedge clk);
        #1 check_reset_state("por");
        rstn = 1'b1;
        model_reset();

        run_frame(1'b0);
        run_frame(1'b1);
        run_frame(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
